can_tx_frame_loader: RTL and testbench

//  Downstream consumer of the 128-bit TX frame FIFO. Pops one queued frame at a time and unpacks it

---
 rtl/can_pkg.sv | 33 +++
 rtl/can_frame_unpack.sv | 33 +++
 rtl/can_tx_frame_loader.sv | 146 ++++++++++++++
 tb/tb_can_tx_frame_loader.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared CAN frame layout and TX loader state encoding.
// The 128-bit queued frame word holds the header fields in its upper half and the payload below.
package can_pkg;

  localparam int CAN_FRAME_W = 128;

  localparam int ID_MSB   = 127;
  localparam int ID_LSB   = 99;
  localparam int IDE_BIT  = 98;
  localparam int RTR_BIT  = 97;
  localparam int DLC_MSB  = 96;
  localparam int DLC_LSB  = 93;
  localparam int RSVD_MSB = 92;
  localparam int RSVD_LSB = 64;
  localparam int DATA_MSB = 63;
  localparam int DATA_LSB = 0;

  localparam int ID_W   = ID_MSB - ID_LSB + 1;
  localparam int DLC_W  = DLC_MSB - DLC_LSB + 1;
  localparam int DATA_W = DATA_MSB - DATA_LSB + 1;
  localparam int BC_W   = 4;

  // DLC codes 9..15 still carry only eight payload bytes on classic CAN.
  localparam logic [BC_W-1:0] MAX_PAYLOAD = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_BUSY    = 2'd2,
    ST_BACKOFF = 2'd3
  } loader_state_t;

endpackage

// File: rtl/can_frame_unpack.sv
// Combinational split of a queued 128-bit frame word into transmitter fields.
// Shared with the RX side, so it carries no state of its own.
module can_frame_unpack
  import can_pkg::*;
(
  input  logic [CAN_FRAME_W-1:0] frame,
  output logic [ID_W-1:0]        id,
  output logic                   ide,
  output logic                   rtr,
  output logic [DLC_W-1:0]       dlc,
  output logic [BC_W-1:0]        byte_count,
  output logic [DATA_W-1:0]      data
);

  logic unused_reserved;

  assign id   = frame[ID_MSB:ID_LSB];
  assign ide  = frame[IDE_BIT];
  assign rtr  = frame[RTR_BIT];
  assign dlc  = frame[DLC_MSB:DLC_LSB];
  assign data = frame[DATA_MSB:DATA_LSB];

  assign unused_reserved = ^frame[RSVD_MSB:RSVD_LSB];

  // Remote frames carry no payload regardless of the DLC they advertise.
  always_comb begin
    byte_count = '0;
    if (!rtr) begin
      byte_count = (dlc > MAX_PAYLOAD) ? MAX_PAYLOAD : dlc;
    end
  end

endmodule

// File: rtl/can_tx_frame_loader.sv
// Pops queued TX frames, presents them to the CAN bit-stream transmitter and tracks the outcome:
// unlimited re-presentation after arbitration loss, bounded retries after errors, drop on bus-off.
module can_tx_frame_loader
  import can_pkg::*;
#(
  parameter int  MAX_RETRIES = 8,
  parameter int  RETRY_GAP   = 16,
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1,
  localparam int GW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1
) (
  input  logic                   i_sys_clk,
  input  logic                   i_reset_n,
  input  logic                   i_tx_en,
  input  logic                   i_fifo_empty,
  input  logic [CAN_FRAME_W-1:0] i_fifo_r_data,
  output logic                   o_fifo_r_en,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  output logic [ID_W-1:0]        o_tx_id,
  output logic                   o_tx_ide,
  output logic                   o_tx_rtr,
  output logic [DLC_W-1:0]       o_tx_dlc,
  output logic [BC_W-1:0]        o_tx_byte_count,
  output logic [DATA_W-1:0]      o_tx_data,
  input  logic                   i_tx_done,
  input  logic                   i_tx_arb_lost,
  input  logic                   i_tx_error,
  input  logic                   i_bus_off,
  output logic                   o_tx_complete,
  output logic                   o_tx_abort,
  output logic [RW-1:0]          o_retry_cnt,
  output logic                   o_busy,
  output loader_state_t          o_dbg_state
);

  loader_state_t          state_q, state_d;
  logic [CAN_FRAME_W-1:0] frame_q, frame_d;
  logic [RW-1:0]          retry_q, retry_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic                   complete_q, complete_d;
  logic                   abort_q, abort_d;
  logic                   run_q;
  logic                   fetch_ok;
  logic                   pop;

  // run_q keeps the pop strobe low until the first clock after reset release; the held
  // complete/abort pulse defers the next pop by one cycle after an outcome.
  assign fetch_ok = run_q && i_tx_en && !i_fifo_empty && !i_bus_off && !complete_q && !abort_q;

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      frame_q    <= '0;
      retry_q    <= '0;
      gap_q      <= '0;
      complete_q <= 1'b0;
      abort_q    <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      retry_q    <= retry_d;
      gap_q      <= gap_d;
      complete_q <= complete_d;
      abort_q    <= abort_d;
      run_q      <= 1'b1;
    end
  end

  // Handshake: o_tx_valid rises only in PRESENT and the fields stay frozen until the cycle
  // where o_tx_valid && i_tx_ready; the frame then counts as accepted and valid drops next cycle.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    retry_d    = retry_q;
    gap_d      = gap_q;
    complete_d = 1'b0;
    abort_d    = 1'b0;
    pop        = 1'b0;

    if (state_q != ST_IDLE && i_bus_off) begin
      abort_d = 1'b1;
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (fetch_ok) begin
            pop     = 1'b1;
            frame_d = i_fifo_r_data;
            retry_d = '0;
            state_d = ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (i_tx_ready) begin
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (i_tx_done) begin
            complete_d = 1'b1;
            state_d    = ST_IDLE;
          end else if (i_tx_error) begin
            if (retry_q == RW'(MAX_RETRIES)) begin
              abort_d = 1'b1;
              state_d = ST_IDLE;
            end else begin
              retry_d = retry_q + RW'(1);
              gap_d   = GW'(RETRY_GAP - 1);
              state_d = ST_BACKOFF;
            end
          end else if (i_tx_arb_lost) begin
            state_d = ST_PRESENT;
          end
        end
        ST_BACKOFF: begin
          if (gap_q == '0) begin
            state_d = ST_PRESENT;
          end else begin
            gap_d = gap_q - GW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  can_frame_unpack u_unpack (
    .frame      (frame_q),
    .id         (o_tx_id),
    .ide        (o_tx_ide),
    .rtr        (o_tx_rtr),
    .dlc        (o_tx_dlc),
    .byte_count (o_tx_byte_count),
    .data       (o_tx_data)
  );

  assign o_fifo_r_en   = pop;
  assign o_tx_valid    = (state_q == ST_PRESENT);
  assign o_busy        = (state_q != ST_IDLE);
  assign o_tx_complete = complete_q;
  assign o_tx_abort    = abort_q;
  assign o_retry_cnt   = retry_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_can_tx_frame_loader.sv
// Directed-plus-random bench for can_tx_frame_loader with a queue-based FIFO and field model.
module tb_can_tx_frame_loader;
  import can_pkg::*;

  localparam int MAX_RETRIES = 2;
  localparam int RETRY_GAP   = 4;
  localparam int RW          = 2;
  localparam int BW          = 103;
  localparam int WAIT_LIMIT  = 40;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          tx_en;
  logic          fifo_empty;
  logic [127:0]  fifo_r_data;
  logic          fifo_r_en;
  logic          tx_valid;
  logic          tx_ready;
  logic [28:0]   tx_id;
  logic          tx_ide;
  logic          tx_rtr;
  logic [3:0]    tx_dlc;
  logic [3:0]    tx_byte_count;
  logic [63:0]   tx_data;
  logic          tx_done;
  logic          tx_arb_lost;
  logic          tx_error;
  logic          bus_off;
  logic          tx_complete;
  logic          tx_abort;
  logic [RW-1:0] retry_cnt;
  logic          busy;
  loader_state_t dbg_state;

  logic [127:0]  fifo_q[$];
  logic [BW-1:0] exp_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            pop_cnt = 0;

  can_tx_frame_loader #(.MAX_RETRIES(MAX_RETRIES), .RETRY_GAP(RETRY_GAP)) dut (
    .i_sys_clk       (clk),
    .i_reset_n       (reset_n),
    .i_tx_en         (tx_en),
    .i_fifo_empty    (fifo_empty),
    .i_fifo_r_data   (fifo_r_data),
    .o_fifo_r_en     (fifo_r_en),
    .o_tx_valid      (tx_valid),
    .i_tx_ready      (tx_ready),
    .o_tx_id         (tx_id),
    .o_tx_ide        (tx_ide),
    .o_tx_rtr        (tx_rtr),
    .o_tx_dlc        (tx_dlc),
    .o_tx_byte_count (tx_byte_count),
    .o_tx_data       (tx_data),
    .i_tx_done       (tx_done),
    .i_tx_arb_lost   (tx_arb_lost),
    .i_tx_error      (tx_error),
    .i_bus_off       (bus_off),
    .o_tx_complete   (tx_complete),
    .o_tx_abort      (tx_abort),
    .o_retry_cnt     (retry_cnt),
    .o_busy          (busy),
    .o_dbg_state     (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // scoreboard primitive
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic fifo_refresh();
    fifo_empty  = (fifo_q.size() == 0);
    fifo_r_data = (fifo_q.size() == 0) ? 128'd0 : fifo_q[0];
  endtask

  // Sample the pop strobe ahead of the edge, let the edge happen, then update the FIFO model.
  task automatic step();
    logic         will_pop;
    logic [127:0] tmp;
    #1;
    will_pop = fifo_r_en;
    @(posedge clk);
    #1;
    if (will_pop) begin
      pop_cnt++;
      if (fifo_q.size() > 0) tmp = fifo_q.pop_front();
      fifo_refresh();
    end
    @(negedge clk);
  endtask

  task automatic push_frame(input logic [28:0] id, input logic ide, input logic rtr,
                            input logic [3:0] dlc, input logic [63:0] data);
    logic [28:0] rsvd;
    logic [3:0]  bc;
    rsvd = 29'($urandom);
    fifo_q.push_back({id, ide, rtr, dlc, rsvd, data});
    if (rtr) bc = 4'd0;
    else if (dlc > 4'd8) bc = 4'd8;
    else bc = dlc;
    exp_q.push_back({id, ide, rtr, dlc, bc, data});
    fifo_refresh();
  endtask

  task automatic push_random();
    push_frame(29'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), {$urandom, $urandom});
  endtask

  task automatic retire();
    logic [BW-1:0] tmp;
    if (exp_q.size() > 0) tmp = exp_q.pop_front();
  endtask

  task automatic check_fields(input string tag);
    logic [BW-1:0] obs;
    logic [BW-1:0] exp;
    obs = {tx_id, tx_ide, tx_rtr, tx_dlc, tx_byte_count, tx_data};
    exp = (exp_q.size() > 0) ? exp_q[0] : '1;
    chk({tag, "_fields"}, 128'(obs), 128'(exp));
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!tx_valid && n < WAIT_LIMIT) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 128'(tx_valid), 128'(1));
  endtask

  task automatic accept(input string tag);
    check_fields(tag);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    chk({tag, "_valid_drop"}, 128'(tx_valid), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(1));
  endtask

  task automatic pulse_done();
    tx_done = 1'b1; step(); tx_done = 1'b0;
  endtask

  task automatic pulse_err();
    tx_error = 1'b1; step(); tx_error = 1'b0;
  endtask

  task automatic pulse_arb();
    tx_arb_lost = 1'b1; step(); tx_arb_lost = 1'b0;
  endtask

  // directed sequence
  initial begin
    int pops0;
    int n;
    logic seen;

    reset_n = 1'b0; tx_en = 1'b0; tx_ready = 1'b0; tx_done = 1'b0;
    tx_arb_lost = 1'b0; tx_error = 1'b0; bus_off = 1'b0;
    fifo_refresh();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 128'(tx_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_r_en", 128'(fifo_r_en), 128'(0));
    chk("rst_complete", 128'(tx_complete), 128'(0));
    chk("rst_abort", 128'(tx_abort), 128'(0));
    chk("rst_retry", 128'(retry_cnt), 128'(0));
    chk("rst_fields", 128'({tx_id, tx_ide, tx_rtr, tx_dlc, tx_byte_count, tx_data}), 128'(0));
    chk("rst_state", 128'(dbg_state), 128'(ST_IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    step(); step();

    // 1: single frame, done five cycles after acceptance
    tx_en = 1'b1;
    pops0 = pop_cnt;
    push_frame(29'h123, 1'b0, 1'b0, 4'd2, 64'hAABB_0000_0000_0000);
    wait_valid("t1");
    chk("t1_byte_count", 128'(tx_byte_count), 128'(2));
    accept("t1");
    repeat (4) step();
    pulse_done();
    chk("t1_complete", 128'(tx_complete), 128'(1));
    chk("t1_no_abort", 128'(tx_abort), 128'(0));
    chk("t1_idle", 128'(busy), 128'(0));
    retire();
    step();
    chk("t1_complete_width", 128'(tx_complete), 128'(0));
    chk("t1_pop_count", 128'(pop_cnt - pops0), 128'(1));

    // 2: DLC clamp and RTR zeroing, then random back-to-back frames
    push_frame(29'h1ABC_DEF0, 1'b1, 1'b1, 4'hF, 64'h0123_4567_89AB_CDEF);
    wait_valid("t2_rtr");
    chk("t2_rtr_dlc", 128'(tx_dlc), 128'(15));
    chk("t2_rtr_bc", 128'(tx_byte_count), 128'(0));
    accept("t2_rtr");
    pulse_done();
    chk("t2_rtr_complete", 128'(tx_complete), 128'(1));
    retire();
    step();
    push_frame(29'h55, 1'b0, 1'b0, 4'hC, 64'hFEDC_BA98_7654_3210);
    wait_valid("t2_dlc12");
    chk("t2_dlc12_bc", 128'(tx_byte_count), 128'(8));
    accept("t2_dlc12");
    pulse_done();
    chk("t2_dlc12_complete", 128'(tx_complete), 128'(1));
    retire();
    step();

    for (int k = 0; k < 8; k++) push_random();
    for (int k = 0; k < 8; k++) begin
      wait_valid("rnd");
      accept("rnd");
      repeat ($urandom_range(0, 3)) step();
      pulse_done();
      chk("rnd_complete", 128'(tx_complete), 128'(1));
      retire();
      #1;
      chk("rnd_no_pop_in_complete_cycle", 128'(fifo_r_en), 128'(0));
      step();
      if (k < 7) begin
        #1;
        chk("rnd_b2b_pop", 128'(fifo_r_en), 128'(1));
      end
    end

    // 3: error retries with backoff, then abort at the limit
    push_random();
    wait_valid("t3");
    accept("t3");
    for (int k = 1; k <= MAX_RETRIES; k++) begin
      pulse_err();
      chk("t3_retry", 128'(retry_cnt), 128'(k));
      chk("t3_state", 128'(dbg_state), 128'(ST_BACKOFF));
      n = 0;
      while (!tx_valid && n < WAIT_LIMIT) begin
        step();
        n++;
      end
      chk("t3_gap", 128'(n), 128'(RETRY_GAP));
      accept("t3_retry");
    end
    pulse_err();
    chk("t3_abort", 128'(tx_abort), 128'(1));
    chk("t3_no_complete", 128'(tx_complete), 128'(0));
    chk("t3_idle", 128'(busy), 128'(0));
    chk("t3_retry_final", 128'(retry_cnt), 128'(MAX_RETRIES));
    retire();
    step();
    chk("t3_abort_width", 128'(tx_abort), 128'(0));

    // 4: stray done in PRESENT ignored; arb-loss re-presents without counting
    push_random();
    wait_valid("t4");
    pulse_done();
    chk("t4_stray_done_valid", 128'(tx_valid), 128'(1));
    chk("t4_stray_done_complete", 128'(tx_complete), 128'(0));
    accept("t4");
    tx_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pulse_arb();
      chk("t4_arb_valid", 128'(tx_valid), 128'(1));
      chk("t4_arb_retry", 128'(retry_cnt), 128'(0));
      accept("t4_arb");
    end
    pulse_done();
    chk("t4_complete", 128'(tx_complete), 128'(1));
    retire();
    step();
    tx_en = 1'b1;

    // 5: bus-off drops the frame and blocks fetching while high
    push_random();
    wait_valid("t5");
    accept("t5");
    step(); step();
    bus_off = 1'b1;
    step();
    chk("t5_abort", 128'(tx_abort), 128'(1));
    chk("t5_no_complete", 128'(tx_complete), 128'(0));
    chk("t5_idle", 128'(busy), 128'(0));
    retire();
    push_random();
    pops0 = pop_cnt;
    step();
    chk("t5_abort_width", 128'(tx_abort), 128'(0));
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (fifo_r_en) seen = 1'b1;
      step();
    end
    chk("t5_no_fetch", 128'(seen), 128'(0));
    chk("t5_pop_count", 128'(pop_cnt - pops0), 128'(0));
    bus_off = 1'b0;
    wait_valid("t5_resume");
    accept("t5_resume");
    pulse_done();
    chk("t5_resume_complete", 128'(tx_complete), 128'(1));
    retire();
    step();

    // 6: done beats error; async reset in PRESENT loses the held frame
    push_random();
    wait_valid("t6");
    accept("t6");
    tx_done = 1'b1; tx_error = 1'b1;
    step();
    tx_done = 1'b0; tx_error = 1'b0;
    chk("t6_complete", 128'(tx_complete), 128'(1));
    chk("t6_no_abort", 128'(tx_abort), 128'(0));
    chk("t6_retry", 128'(retry_cnt), 128'(0));
    retire();
    step();

    push_random();
    push_random();
    wait_valid("t6_pre_rst");
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 128'(tx_valid), 128'(0));
    chk("t6_rst_busy", 128'(busy), 128'(0));
    chk("t6_rst_r_en", 128'(fifo_r_en), 128'(0));
    chk("t6_rst_fields", 128'({tx_id, tx_ide, tx_rtr, tx_dlc, tx_byte_count, tx_data}), 128'(0));
    chk("t6_rst_pulses", 128'({tx_complete, tx_abort}), 128'(0));
    pops0 = pop_cnt;
    step(); step();
    chk("t6_rst_no_pop", 128'(pop_cnt - pops0), 128'(0));
    retire();
    reset_n = 1'b1;
    wait_valid("t6_post_rst");
    accept("t6_post_rst");
    pulse_done();
    chk("t6_post_rst_complete", 128'(tx_complete), 128'(1));
    retire();
    step();
    chk("end_fifo_drained", 128'(fifo_q.size()), 128'(0));
    chk("end_exp_drained", 128'(exp_q.size()), 128'(0));

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
